// File: rtl/bch_err_channel.sv
// Serial error-injection channel for BCH codewords: flips up to MAX_ERR bit
// positions per frame, taken from fixed inputs or from an internal LFSR.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start; in_valid ignored
// S_GEN    | random mode: stepping the LFSR to fill the error slots
// S_STREAM | passing bits through with a 1-cycle latency, flipping hits
// S_DONE   | one-cycle done pulse, aligned with the last output bit
module bch_err_channel #(
  parameter int N       = 63,
  parameter int POS_W   = 7,
  parameter int MAX_ERR = 3,
  parameter int ERR_W   = 2,
  parameter logic [POS_W-1:0] TAPS = 7'b1100000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode,
  input  logic [ERR_W-1:0]         ne,
  input  logic [MAX_ERR*POS_W-1:0] pos,
  input  logic [POS_W-1:0]         seed,
  input  logic                     in_valid,
  input  logic                     in_bit,
  output logic                     out_valid,
  output logic                     out_bit,
  output logic                     busy,
  output logic                     done,
  output logic [ERR_W-1:0]         err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_STREAM,
    S_DONE
  } state_t;

  localparam logic [POS_W-1:0] N_POS    = POS_W'(N);
  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(N - 1);
  localparam logic [ERR_W-1:0] MAX_CNT  = ERR_W'(MAX_ERR);

  state_t             state;
  logic [ERR_W-1:0]   ne_eff;
  logic [ERR_W-1:0]   fill_cnt;
  logic [POS_W-1:0]   lfsr;
  logic [POS_W-1:0]   idx;
  logic [POS_W-1:0]   slot_pos [MAX_ERR];
  logic [MAX_ERR-1:0] slot_act;

  logic [ERR_W-1:0]   ne_clip;
  logic [POS_W-1:0]   seed_eff;
  logic [POS_W-1:0]   lfsr_nxt;
  logic               cand_dup;
  logic               accept;
  logic               fill_last;
  logic               hit;

  always_comb begin
    ne_clip  = (ne > MAX_CNT) ? MAX_CNT : ne;
    seed_eff = (seed == '0) ? POS_W'(1) : seed;
  end

  // Fibonacci step: feedback is the parity of the tapped bits, shifted in at bit 0.
  always_comb begin
    lfsr_nxt = {lfsr[POS_W-2:0], ^(lfsr & TAPS)};
    cand_dup = 1'b0;
    for (int k = 0; k < MAX_ERR; k++) begin
      if (slot_act[k] && (slot_pos[k] == lfsr_nxt)) cand_dup = 1'b1;
    end
    accept    = (lfsr_nxt < N_POS) && !cand_dup;
    fill_last = (ERR_W'(fill_cnt + 1'b1) == ne_eff);
  end

  // Duplicate positions OR together, so a bit is never flipped back.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < MAX_ERR; k++) begin
      if (slot_act[k] && (slot_pos[k] == idx)) hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ne_eff    <= '0;
      fill_cnt  <= '0;
      lfsr      <= '0;
      idx       <= '0;
      slot_act  <= '0;
      for (int k = 0; k < MAX_ERR; k++) slot_pos[k] <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ne_eff   <= ne_clip;
            fill_cnt <= '0;
            lfsr     <= seed_eff;
            idx      <= '0;
            err_cnt  <= '0;
            busy     <= 1'b1;
            // Fixed mode arms slots now; random mode fills them during GEN.
            for (int k = 0; k < MAX_ERR; k++) begin
              slot_pos[k] <= pos[k*POS_W +: POS_W];
              slot_act[k] <= !mode && (ERR_W'(k) < ne_clip) &&
                             (pos[k*POS_W +: POS_W] < N_POS);
            end
            state <= (mode && (ne_clip != '0)) ? S_GEN : S_STREAM;
          end
        end

        S_GEN: begin
          lfsr <= lfsr_nxt;
          if (accept) begin
            for (int k = 0; k < MAX_ERR; k++) begin
              if (fill_cnt == ERR_W'(k)) begin
                slot_pos[k] <= lfsr_nxt;
                slot_act[k] <= 1'b1;
              end
            end
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_last) state <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (in_valid) begin
            out_valid <= 1'b1;
            out_bit   <= in_bit ^ hit;
            idx       <= idx + 1'b1;
            if (hit && (err_cnt != MAX_CNT)) err_cnt <= err_cnt + 1'b1;
            if (idx == LAST_IDX) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
